// File: rtl/control_unit_if.sv
// Decoder bus: instruction fields in, registered datapath controls out.
interface control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       rf_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic       illegal;

    // Fetch/issue side drives the fields and consumes the controls.
    modport master (
        output opcode, funct3, funct7,
        input  alu_op, alu_src, rf_we, mem_re, mem_we, pc_src, imm_sel, illegal
    );

    // Decoder side.
    modport slave (
        input  opcode, funct3, funct7,
        output alu_op, alu_src, rf_we, mem_re, mem_we, pc_src, imm_sel, illegal
    );
endinterface

// File: rtl/control_unit.sv
// RV32I main decoder. Combinational decode of opcode/funct3/funct7,
// registered once so controls appear one clock after the fields.
module control_unit (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 -> ALU op for the base (funct7 = 0) R/I arithmetic forms.
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [3:0] alu_op_d;
    logic       alu_src_d;
    logic       rf_we_d;
    logic       mem_re_d;
    logic       mem_we_d;
    logic [1:0] pc_src_d;
    logic [2:0] imm_sel_d;
    logic       illegal_d;

    // Next-cycle controls. funct7/funct3 are only examined inside the
    // opcode arms that use them, so X on unused fields cannot leak out.
    always_comb begin
        alu_op_d  = ALU_ADD;
        alu_src_d = 1'b0;
        rf_we_d   = 1'b0;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        pc_src_d  = PC_PLUS4;
        imm_sel_d = IMM_NONE;
        illegal_d = 1'b0;

        case (bus.opcode)
            OP_R: begin
                rf_we_d = 1'b1;
                if (bus.funct7 == F7_BASE)
                    alu_op_d = base_alu(bus.funct3);
                else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000)
                    alu_op_d = ALU_SUB;
                else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101)
                    alu_op_d = ALU_SRA;
                else
                    illegal_d = 1'b1;
            end
            OP_I: begin
                rf_we_d   = 1'b1;
                alu_src_d = 1'b1;
                imm_sel_d = IMM_I;
                alu_op_d  = base_alu(bus.funct3);
                // Only the shift forms carry meaning in funct7.
                if (bus.funct3 == 3'b001) begin
                    if (bus.funct7 != F7_BASE) illegal_d = 1'b1;
                end else if (bus.funct3 == 3'b101) begin
                    if (bus.funct7 == F7_ALT)       alu_op_d  = ALU_SRA;
                    else if (bus.funct7 != F7_BASE) illegal_d = 1'b1;
                end
            end
            OP_LOAD: begin
                rf_we_d   = 1'b1;
                mem_re_d  = 1'b1;
                alu_src_d = 1'b1;
                imm_sel_d = IMM_I;
                case (bus.funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_STORE: begin
                mem_we_d  = 1'b1;
                alu_src_d = 1'b1;
                imm_sel_d = IMM_S;
                case (bus.funct3)
                    3'b000, 3'b001, 3'b010: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                pc_src_d  = PC_BRANCH;
                imm_sel_d = IMM_B;
                case (bus.funct3)
                    3'b000, 3'b001: alu_op_d = ALU_SUB;
                    3'b100, 3'b101: alu_op_d = ALU_SLT;
                    3'b110, 3'b111: alu_op_d = ALU_SLTU;
                    default:        illegal_d = 1'b1;
                endcase
            end
            OP_JAL: begin
                rf_we_d   = 1'b1;
                pc_src_d  = PC_JAL;
                imm_sel_d = IMM_J;
            end
            OP_JALR: begin
                rf_we_d   = 1'b1;
                pc_src_d  = PC_JALR;
                alu_src_d = 1'b1;
                imm_sel_d = IMM_I;
                if (bus.funct3 != 3'b000) illegal_d = 1'b1;
            end
            OP_LUI: begin
                rf_we_d   = 1'b1;
                alu_src_d = 1'b1;
                alu_op_d  = ALU_PASS_B;
                imm_sel_d = IMM_U;
            end
            OP_AUIPC: begin
                rf_we_d   = 1'b1;
                alu_src_d = 1'b1;
                imm_sel_d = IMM_U;
            end
            default: illegal_d = 1'b1;
        endcase

        // A trapping instruction must have no architectural side effects,
        // so collapse everything back to the NOP pattern.
        if (illegal_d) begin
            alu_op_d  = ALU_ADD;
            alu_src_d = 1'b0;
            rf_we_d   = 1'b0;
            mem_re_d  = 1'b0;
            mem_we_d  = 1'b0;
            pc_src_d  = PC_PLUS4;
            imm_sel_d = IMM_NONE;
        end
    end

    // Output register; reset clears everything and drops the pending decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_op  <= 4'b0000;
            bus.alu_src <= 1'b0;
            bus.rf_we   <= 1'b0;
            bus.mem_re  <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.pc_src  <= 2'b00;
            bus.imm_sel <= 3'b000;
            bus.illegal <= 1'b0;
        end else begin
            bus.alu_op  <= alu_op_d;
            bus.alu_src <= alu_src_d;
            bus.rf_we   <= rf_we_d;
            bus.mem_re  <= mem_re_d;
            bus.mem_we  <= mem_we_d;
            bus.pc_src  <= pc_src_d;
            bus.imm_sel <= imm_sel_d;
            bus.illegal <= illegal_d;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step applies one encoding, checks
// the outputs still hold the previous result before the edge, then checks
// the hand-computed controls one edge later.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    control_unit_if bus();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {alu_op, alu_src, rf_we, mem_re, mem_we, pc_src, imm_sel, illegal}
    logic [13:0] out;
    assign out = {bus.alu_op, bus.alu_src, bus.rf_we, bus.mem_re, bus.mem_we,
                  bus.pc_src, bus.imm_sel, bus.illegal};

    function automatic logic [13:0] e(input logic [3:0] alu, input logic src,
                                      input logic we, input logic re,
                                      input logic mwe, input logic [1:0] pc,
                                      input logic [2:0] imm, input logic ill);
        return {alu, src, we, re, mwe, pc, imm, ill};
    endfunction

    localparam logic [13:0] ZERO = 14'b0;
    localparam logic [13:0] ILL  = 14'b0000_0_0_0_0_00_111_1;

    logic [13:0] prev;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [13:0] exp);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        #1;
        check({tag, "_hold"}, out, prev);
        @(posedge clk);
        #1;
        check(tag, out, exp);
        prev = exp;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.opcode = 7'b0110011;
        bus.funct3 = 3'b000;
        bus.funct7 = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        check("reset", out, ZERO);
        prev  = ZERO;
        rst_n = 1'b1;

        apply("r_add",   7'b0110011, 3'b000, 7'b0000000, e(4'd0, 0, 1, 0, 0, 2'd0, 3'd7, 0));
        apply("r_sub",   7'b0110011, 3'b000, 7'b0100000, e(4'd1, 0, 1, 0, 0, 2'd0, 3'd7, 0));
        apply("addi_x",  7'b0010011, 3'b000, 7'bxxxxxxx, e(4'd0, 1, 1, 0, 0, 2'd0, 3'd0, 0));
        tests++;
        assert (!$isunknown(out)) else begin
            fails++;
            $error("FAIL addi_known: observed %b expected no X", out);
        end
        apply("r_sra",   7'b0110011, 3'b101, 7'b0100000, e(4'd7, 0, 1, 0, 0, 2'd0, 3'd7, 0));
        apply("r_or",    7'b0110011, 3'b110, 7'b0000000, e(4'd8, 0, 1, 0, 0, 2'd0, 3'd7, 0));
        apply("r_badf7", 7'b0110011, 3'b000, 7'b0000001, ILL);
        apply("r_xor_alt", 7'b0110011, 3'b100, 7'b0100000, ILL);
        apply("srai",    7'b0010011, 3'b101, 7'b0100000, e(4'd7, 1, 1, 0, 0, 2'd0, 3'd0, 0));
        apply("srli",    7'b0010011, 3'b101, 7'b0000000, e(4'd6, 1, 1, 0, 0, 2'd0, 3'd0, 0));
        apply("slli_bad", 7'b0010011, 3'b001, 7'b0100000, ILL);
        apply("andi",    7'b0010011, 3'b111, 7'b1111111, e(4'd9, 1, 1, 0, 0, 2'd0, 3'd0, 0));
        apply("lw",      7'b0000011, 3'b010, 7'b0000000, e(4'd0, 1, 1, 1, 0, 2'd0, 3'd0, 0));
        apply("load_bad", 7'b0000011, 3'b011, 7'b0000000, ILL);
        apply("sw",      7'b0100011, 3'b010, 7'b0000000, e(4'd0, 1, 0, 0, 1, 2'd0, 3'd1, 0));
        apply("store_bad", 7'b0100011, 3'b100, 7'b0000000, ILL);
        apply("beq",     7'b1100011, 3'b000, 7'b0000000, e(4'd1, 0, 0, 0, 0, 2'd1, 3'd2, 0));
        apply("bltu",    7'b1100011, 3'b110, 7'b0000000, e(4'd4, 0, 0, 0, 0, 2'd1, 3'd2, 0));
        apply("blt",     7'b1100011, 3'b100, 7'b0000000, e(4'd3, 0, 0, 0, 0, 2'd1, 3'd2, 0));
        apply("br_bad",  7'b1100011, 3'b010, 7'b0000000, ILL);
        apply("jal_x",   7'b1101111, 3'bxxx, 7'bxxxxxxx, e(4'd0, 0, 1, 0, 0, 2'd2, 3'd4, 0));
        tests++;
        assert (!$isunknown(out)) else begin
            fails++;
            $error("FAIL jal_known: observed %b expected no X", out);
        end
        apply("jalr",    7'b1100111, 3'b000, 7'b0000000, e(4'd0, 1, 1, 0, 0, 2'd3, 3'd0, 0));
        apply("jalr_bad", 7'b1100111, 3'b001, 7'b0000000, ILL);
        apply("lui",     7'b0110111, 3'b101, 7'b1010101, e(4'd10, 1, 1, 0, 0, 2'd0, 3'd3, 0));
        apply("auipc",   7'b0010111, 3'b011, 7'b0000000, e(4'd0, 1, 1, 0, 0, 2'd0, 3'd3, 0));
        apply("op_bad",  7'b1111111, 3'b000, 7'b0000000, ILL);
        apply("r_and",   7'b0110011, 3'b111, 7'b0000000, e(4'd9, 0, 1, 0, 0, 2'd0, 3'd7, 0));

        // Reset arriving with a load pending: the load must be discarded.
        rst_n      = 1'b0;
        bus.opcode = 7'b0000011;
        bus.funct3 = 3'b010;
        bus.funct7 = 7'b0000000;
        @(posedge clk);
        #1;
        check("mid_reset", out, ZERO);
        prev  = ZERO;
        rst_n = 1'b1;
        apply("lw_after_reset", 7'b0000011, 3'b010, 7'b0000000, e(4'd0, 1, 1, 1, 0, 2'd0, 3'd0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for an RV32I single-issue core.
- Maps opcode/funct3/funct7 of the current instruction to ALU, register-file, memory, PC-select and immediate-select controls.
- Outputs are registered (one clock of latency) and feed the execute/memory/writeback datapath.
- Flags unsupported encodings so the core can trap.

Parameters:
- none

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- alu_op  out  4  ALU operation code
- alu_src  out  1  ALU operand B select: 0 = rs2, 1 = immediate
- rf_we  out  1  register-file write enable
- mem_re  out  1  data-memory read enable
- mem_we  out  1  data-memory write enable
- pc_src  out  2  next-PC select: 00 PC+4, 01 branch target (taken-resolution done outside), 10 JAL target, 11 JALR target
- imm_sel  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none
- illegal  out  1  unsupported or malformed encoding

Behaviour:
- alu_op encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASS_B 1010; 1011-1111 unused.
- Decode is combinational on the inputs. Result registers on each rising clk. Outputs reflect the inputs sampled at the previous edge (latency 1). No handshake; decodes every cycle.
- Reset (rst_n=0 at edge): all outputs 0 (alu_op ADD, imm_sel 000, pc_src 00, illegal 0). Reset mid-stream discards the pending decode.
- Default / NOP values for any field not listed: alu_op 0000, alu_src 0, rf_we 0, mem_re 0, mem_we 0, pc_src 00, imm_sel 111, illegal 0.
- Decode is selected by opcode only. Fields a format does not use (funct7 for non-R/non-shift; funct3 for LUI/AUIPC/JAL) must not influence outputs; X on them yields fully known outputs.
- R-type 0110011:
  - rf_we 1, alu_src 0, imm_sel 111.
  - funct3 000/001/010/011/100/101/110/111 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 with funct3 000 -> SUB; with funct3 101 -> SRA.
  - Any other funct7 -> illegal.
- I-ALU 0010011:
  - rf_we 1, alu_src 1, imm_sel 000, same funct3 map.
  - funct3 001 requires funct7 0000000.
  - funct3 101: funct7 0000000 -> SRL, 0100000 -> SRA; other funct7 -> illegal.
  - funct3 000 is ADD regardless of funct7.
- Load 0000011: rf_we 1, mem_re 1, alu_src 1, alu_op ADD, imm_sel 000. funct3 in {000,001,010,100,101}, else illegal.
- Store 0100011: mem_we 1, alu_src 1, alu_op ADD, imm_sel 001. funct3 in {000,001,010}, else illegal.
- Branch 1100011: pc_src 01, alu_src 0, imm_sel 010, rf_we 0. funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
- JAL 1101111: rf_we 1, pc_src 10, imm_sel 100, alu_op ADD, alu_src 0.
- JALR 1100111: rf_we 1, pc_src 11, imm_sel 000, alu_op ADD, alu_src 1. funct3 must be 000, else illegal.
- LUI 0110111: rf_we 1, alu_src 1, alu_op PASS_B, imm_sel 011.
- AUIPC 0010111: rf_we 1, alu_src 1, alu_op ADD, imm_sel 011. Operand-A = PC selection is handled outside this block.
- Any other opcode, or any illegal case above: NOP default values with illegal 1. rf_we, mem_re, mem_we and pc_src are forced 0 whenever illegal=1.
- mem_re and mem_we are never both 1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with opcode=0110011 -> all outputs 0. Release: next edge R-type ADD (funct3 000, funct7 0000000) -> alu_op 0000, alu_src 0, rf_we 1, pc_src 00, imm_sel 111.
- R-type SUB (funct7 0100000) -> alu_op 0001. Then ADDI with funct7=X -> alu_op 0000, alu_src 1, rf_we 1, imm_sel 000, no X on any output.
- LW (0000011/010) -> alu_op 0000, alu_src 1, rf_we 1, mem_re 1, mem_we 0, imm_sel 000. SW (0100011/010) -> mem_we 1, rf_we 0, imm_sel 001.
- BEQ (1100011/000) -> alu_op 0001, alu_src 0, rf_we 0, pc_src 01, imm_sel 010. BLTU (110) -> alu_op 0100.
- JAL (funct3/funct7 X) -> rf_we 1, pc_src 10, imm_sel 100. JALR (1100111/000) -> alu_src 1, rf_we 1, pc_src 11, imm_sel 000. LUI -> rf_we 1, imm_sel 011, alu_op 1010.
- Illegal: opcode 1111111 -> illegal 1, rf_we 0, mem_we 0, pc_src 00. Also each output changes exactly one edge after its input changes.
